fetch_sequencer: RTL

- Program-counter sequencer and fetch controller for the synchronous-read instruction memory (32-bit words, 1024 entries, read data valid one clock after the address is sampled).
- Generates the fetch address and tracks the 1-cycle in-flight read.
- Buffers returned words in a 2-entry queue and presents them to decode through a valid/ready handshake.
- Supports start, redirect (branch/jump flush) and end-of-program drain.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_sequencer_if.sv | 17 +
 rtl/fetch_queue.sv | 64 ++++++
 rtl/fetch_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    localparam int FETCH_DATA_WIDTH  = 32;
    localparam int FETCH_ADDR_WIDTH  = 10;
    localparam int FETCH_QUEUE_DEPTH = 2;
    localparam int FETCH_OCC_WIDTH   = $clog2(FETCH_QUEUE_DEPTH + 1);

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch-to-decode instruction handshake
// master: instr_valid/instr_data/instr_pc out, instr_ready in (sequencer side)
// slave : instr_valid/instr_data/instr_pc in, instr_ready out (decode side)
import fetch_pkg::*;

interface fetch_sequencer_if #(
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH
) ();
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0] instr_pc;

    modport master (output instr_valid, output instr_data, output instr_pc, input instr_ready);
    modport slave  (input instr_valid, input instr_data, input instr_pc, output instr_ready);
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry {pc, data} FIFO with flush
// in : clk, rst_n, flush, push, push_pc, push_data, pop
// out: head_pc, head_data (entry 0), occupancy
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [ADDR_WIDTH-1:0]      push_pc,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [ADDR_WIDTH-1:0]      head_pc,
    output logic [DATA_WIDTH-1:0]      head_data,
    output logic [FETCH_OCC_WIDTH-1:0] occupancy
);
    logic [ADDR_WIDTH-1:0]      pc0, pc1;
    logic [DATA_WIDTH-1:0]      d0, d1;
    logic [FETCH_OCC_WIDTH-1:0] occ, occ_after_pop;
    logic                       pop_ok, push_ok;

    always_comb begin
        pop_ok        = pop && (occ != '0);
        // A full queue still accepts a push when the head leaves in the same cycle.
        push_ok       = push && ((occ < FETCH_OCC_WIDTH'(FETCH_QUEUE_DEPTH)) || pop_ok);
        occ_after_pop = occ - FETCH_OCC_WIDTH'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
            pc0 <= '0;
            pc1 <= '0;
            d0  <= '0;
            d1  <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            if (pop_ok) begin
                pc0 <= pc1;
                d0  <= d1;
            end
            // Later assignment to slot 0 wins over the shift when the queue drains to empty.
            if (push_ok) begin
                if (occ_after_pop == '0) begin
                    pc0 <= push_pc;
                    d0  <= push_data;
                end else begin
                    pc1 <= push_pc;
                    d1  <= push_data;
                end
            end
            occ <= occ_after_pop + FETCH_OCC_WIDTH'(push_ok);
        end
    end

    assign head_pc   = pc0;
    assign head_data = d0;
    assign occupancy = occ;
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencer and fetch controller for a 1-cycle synchronous instruction memory
// in : clk, rst_n (async, active-low), start, start_addr, imem_data, redirect_valid, redirect_addr
// out: imem_addr, busy (FETCH/DRAIN), done (DONE)
// dec: fetch_sequencer_if.master (instr_valid/instr_data/instr_pc/instr_ready)
// Optional: FETCH_STALL_CNT_EN adds stall_cnt[15:0], saturating count of stalled valid cycles
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int LAST_ADDR  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    fetch_sequencer_if.master     dec,
    output logic                  busy,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic                  done
);
    fetch_state_t               state, state_nxt;
    logic [ADDR_WIDTH-1:0]      pc, pc_nxt, tag, tag_nxt;
    logic                       inflight;
    logic [FETCH_OCC_WIDTH-1:0] occ;
    logic                       pop, start_ok, flush, issue, room;

    always_comb begin
        pop      = dec.instr_valid && dec.instr_ready;
        start_ok = start && ((state == IDLE) || (state == DONE));
        flush    = redirect_valid && ((state == FETCH) || (state == DRAIN));
        // Words held plus the one in flight, minus the one leaving, must stay below depth.
        room     = (3'(occ) + 3'(inflight)) < (3'(FETCH_QUEUE_DEPTH) + 3'(pop));
        issue    = (state == FETCH) && !flush && room;
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        tag_nxt   = issue ? pc : tag;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_nxt = FETCH;
                    pc_nxt    = start_addr;
                end
            end
            FETCH: begin
                if (flush) begin
                    pc_nxt = redirect_addr;
                end else if (issue) begin
                    pc_nxt = pc + ADDR_WIDTH'(1);
                    if (pc == ADDR_WIDTH'(LAST_ADDR)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_nxt = FETCH;
                    pc_nxt    = redirect_addr;
                end else if ((occ == '0) && !inflight) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            tag      <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            tag      <= tag_nxt;
            inflight <= issue;
        end
    end

    fetch_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (inflight),
        .push_pc   (tag),
        .push_data (imem_data),
        .pop       (pop),
        .head_pc   (dec.instr_pc),
        .head_data (dec.instr_data),
        .occupancy (occ)
    );

    assign dec.instr_valid = (occ != '0);
    assign imem_addr       = pc;
    assign busy            = (state == FETCH) || (state == DRAIN);
    assign done            = (state == DONE);

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (start_ok) begin
            stall_cnt <= '0;
        end else if (dec.instr_valid && !dec.instr_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule
